// File: rtl/conv_pool_pkg.sv
// ============================================================================
// conv_pool_pkg
//   Shared widths, types and helpers for the conv_pool engine.
//   Contents: pixel/weight/accumulator typedefs, fetch state encoding,
//             and the ReLU -> logical shift -> saturate output function.
// ============================================================================
`default_nettype none

package conv_pool_pkg;

  localparam int PIX_W = 8;               // pixel width (unsigned)
  localparam int WGT_W = 8;               // weight width (signed)
  localparam int ACC_W = 20;              // conv accumulator width (signed)
  localparam int KSZ   = 3;               // kernel is KSZ x KSZ
  localparam int BLK   = 4;               // input block is BLK x BLK
  localparam int WIN   = BLK - KSZ + 1;   // valid-mode result is WIN x WIN

  typedef logic        [PIX_W-1:0] pix_t;
  typedef logic signed [WGT_W-1:0] wgt_t;
  typedef logic signed [ACC_W-1:0] acc_t;

  typedef enum logic [1:0] {
    FS_IDLE  = 2'd0,   // held in reset, nothing fetched yet
    FS_FETCH = 2'd1,   // one block address issued per cycle
    FS_DONE  = 2'd2    // run complete, idle until next reset
  } fetch_state_t;

  // Negative maxima clamp to zero, then the shift is logical on a
  // non-negative value; anything left above 8 bits saturates to 255.
  function automatic pix_t relu_shift_sat(input acc_t m, input logic [1:0] sh);
    logic [ACC_W-1:0] t;
    t = m[ACC_W-1] ? '0 : m;
    t = t >> sh;
    return (|t[ACC_W-1:PIX_W]) ? '1 : t[PIX_W-1:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/conv_pool_lane.sv
// ============================================================================
// conv_pool_lane
//   One output channel: 3x3 valid convolution over a 4x4 block (four window
//   sums), then 2x2 max-pool, ReLU, shift and saturate. Two register stages.
//   Ports: clk, rst_n         - clock, async active-low reset
//          image, kernel      - block pixels and 3x3 weights (same cycle)
//          shift              - right shift for this block (same cycle)
//          en_s1              - image/kernel/shift are valid this cycle
//          en_s2              - stage-1 holds a valid block
//          y                  - pooled 8-bit result (holds when en_s2 low)
// ============================================================================
`default_nettype none

module conv_pool_lane
  import conv_pool_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [BLK*BLK*PIX_W-1:0]   image,
  input  logic [KSZ*KSZ*WGT_W-1:0]   kernel,
  input  logic [1:0]                 shift,
  input  logic                       en_s1,
  input  logic                       en_s2,
  output logic [PIX_W-1:0]           y
);

  acc_t       sum_c [WIN*WIN];
  acc_t       sum_q [WIN*WIN];
  logic [1:0] shift_q;
  acc_t       max_c;

  // Window w covers rows w/WIN.., cols w%WIN... Pixels are zero-extended
  // and weights sign-extended to the accumulator width before multiplying,
  // so the 8u x 8s product is exact.
  always_comb begin
    for (int w = 0; w < WIN*WIN; w++) begin
      sum_c[w] = '0;
      for (int i = 0; i < KSZ; i++) begin
        for (int j = 0; j < KSZ; j++) begin
          sum_c[w] = sum_c[w]
            + acc_t'({1'b0, image[PIX_W*(BLK*(w/WIN + i) + (w%WIN) + j) +: PIX_W]})
            * acc_t'(wgt_t'(kernel[WGT_W*(KSZ*i + j) +: WGT_W]));
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WIN*WIN; w++) sum_q[w] <= '0;
      shift_q <= '0;
    end else if (en_s1) begin
      for (int w = 0; w < WIN*WIN; w++) sum_q[w] <= sum_c[w];
      shift_q <= shift;
    end
  end

  always_comb begin
    max_c = sum_q[0];
    for (int w = 1; w < WIN*WIN; w++) begin
      if (sum_q[w] > max_c) max_c = sum_q[w];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     y <= '0;
    else if (en_s2) y <= relu_shift_sat(max_c, shift_q);
  end

endmodule

`default_nettype wire

// File: rtl/conv_pool.sv
// ============================================================================
// conv_pool
//   Streaming 3-channel 3x3 convolution + 2x2 max-pool engine. Issues one
//   block read per cycle for NUM_BLKS blocks, then writes one pooled value
//   per channel per block three cycles after its address was issued.
//   Ports: clk, rst_n                   - clock, async active-low reset
//          image_4x4                    - block data, valid 1 cycle after read
//          conv_kernel_0/1/2, shift     - sampled together with image_4x4
//          input_re, input_addr         - input memory read port
//          output_we_k, output_addr_k,
//          y_k                          - per-channel output memory write
// ============================================================================
`default_nettype none

module conv_pool
  import conv_pool_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int NUM_BLKS = 65536
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BLK*BLK*PIX_W-1:0]  image_4x4,
  input  logic [KSZ*KSZ*WGT_W-1:0]  conv_kernel_0,
  input  logic [KSZ*KSZ*WGT_W-1:0]  conv_kernel_1,
  input  logic [KSZ*KSZ*WGT_W-1:0]  conv_kernel_2,
  input  logic [1:0]                shift,
  output logic                      input_re,
  output logic [ADDR_W-1:0]         input_addr,
  output logic                      output_we_0,
  output logic                      output_we_1,
  output logic                      output_we_2,
  output logic [ADDR_W-1:0]         output_addr_0,
  output logic [ADDR_W-1:0]         output_addr_1,
  output logic [ADDR_W-1:0]         output_addr_2,
  output logic [PIX_W-1:0]          y_0,
  output logic [PIX_W-1:0]          y_1,
  output logic [PIX_W-1:0]          y_2
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BLKS - 1);

  fetch_state_t       state, state_nx;
  logic [ADDR_W-1:0]  blk_cnt;

  // Valid/address pipeline: rd_* = data arriving from memory,
  // s1_* = convolution sums registered, out_* = write stage.
  logic               rd_vld, s1_vld, out_vld;
  logic [ADDR_W-1:0]  rd_addr, s1_addr, out_addr;

  logic [KSZ*KSZ*WGT_W-1:0] kernels [3];
  logic [PIX_W-1:0]         y_lane  [3];

  // ---------------- fetch controller ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FS_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      FS_IDLE:  state_nx = FS_FETCH;
      FS_FETCH: if (blk_cnt == LAST_ADDR) state_nx = FS_DONE;
      FS_DONE:  state_nx = FS_DONE;   // sticky until reset; no wrap-around
      default:  state_nx = FS_IDLE;
    endcase
  end

  always_comb begin
    input_re   = (state == FS_FETCH);
    input_addr = blk_cnt;
  end

  // Counter stops on the last address so input_addr holds it once done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      blk_cnt <= '0;
    else if (state == FS_FETCH && blk_cnt != LAST_ADDR)
      blk_cnt <= blk_cnt + 1'b1;
  end

  // ---------------- valid / address pipeline ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld   <= 1'b0;
      rd_addr  <= '0;
      s1_vld   <= 1'b0;
      s1_addr  <= '0;
      out_vld  <= 1'b0;
      out_addr <= '0;
    end else begin
      rd_vld  <= input_re;
      rd_addr <= input_addr;
      s1_vld  <= rd_vld;
      if (rd_vld) s1_addr <= rd_addr;
      out_vld <= s1_vld;
      if (s1_vld) out_addr <= s1_addr;   // hold last address between writes
    end
  end

  // ---------------- channel lanes ----------------
  assign kernels[0] = conv_kernel_0;
  assign kernels[1] = conv_kernel_1;
  assign kernels[2] = conv_kernel_2;

  for (genvar k = 0; k < 3; k++) begin : g_lane
    conv_pool_lane u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .image  (image_4x4),
      .kernel (kernels[k]),
      .shift  (shift),
      .en_s1  (rd_vld),
      .en_s2  (s1_vld),
      .y      (y_lane[k])
    );
  end

  assign output_we_0   = out_vld;
  assign output_we_1   = out_vld;
  assign output_we_2   = out_vld;
  assign output_addr_0 = out_addr;
  assign output_addr_1 = out_addr;
  assign output_addr_2 = out_addr;
  assign y_0           = y_lane[0];
  assign y_1           = y_lane[1];
  assign y_2           = y_lane[2];

endmodule

`default_nettype wire

// File: tb/tb_conv_pool.sv
// ============================================================================
// tb_conv_pool
//   Self-checking bench for conv_pool. A behavioural synchronous memory
//   returns a block (plus kernels/shift) one cycle after each read; the
//   expected per-channel results are pushed to a scoreboard at that point
//   and compared against every output write.
// ============================================================================
`default_nettype none

module tb_conv_pool;

  localparam int ADDR_W   = 16;
  localparam int NUM_BLKS = 65536;

  logic              clk;
  logic              rst_n;
  logic [127:0]      image_4x4;
  logic [71:0]       conv_kernel_0, conv_kernel_1, conv_kernel_2;
  logic [1:0]        shift;
  logic              input_re;
  logic [ADDR_W-1:0] input_addr;
  logic              output_we_0, output_we_1, output_we_2;
  logic [ADDR_W-1:0] output_addr_0, output_addr_1, output_addr_2;
  logic [7:0]        y_0, y_1, y_2;

  conv_pool #(.ADDR_W(ADDR_W), .NUM_BLKS(NUM_BLKS)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .image_4x4     (image_4x4),
    .conv_kernel_0 (conv_kernel_0),
    .conv_kernel_1 (conv_kernel_1),
    .conv_kernel_2 (conv_kernel_2),
    .shift         (shift),
    .input_re      (input_re),
    .input_addr    (input_addr),
    .output_we_0   (output_we_0),
    .output_we_1   (output_we_1),
    .output_we_2   (output_we_2),
    .output_addr_0 (output_addr_0),
    .output_addr_1 (output_addr_1),
    .output_addr_2 (output_addr_2),
    .y_0           (y_0),
    .y_1           (y_1),
    .y_2           (y_2)
  );

  typedef struct {
    int         addr;
    logic [7:0] y0, y1, y2;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc   = -1;     // cycle index; 0 = first cycle after release
  int          n_wr  = 0;
  int          last_wr_addr = -1;
  int          last_wr_cyc  = -1;
  logic [23:0] last_y = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_re"},   {31'd0, input_re}, 0);
    check({tag, "_addr"}, {16'd0, input_addr}, 0);
    check({tag, "_we"},   {29'd0, output_we_0, output_we_1, output_we_2}, 0);
    check({tag, "_oaddr"}, {output_addr_0 | output_addr_1 | output_addr_2}, 0);
    check({tag, "_y"},    {8'd0, y_0, y_1, y_2}, 0);
  endtask

  // ---------------- stimulus content ----------------
  function automatic logic [31:0] mix(input logic [31:0] x);
    x = x ^ (x >> 16);
    x = x * 32'h7feb352d;
    x = x ^ (x >> 15);
    x = x * 32'h846ca68b;
    x = x ^ (x >> 16);
    return x;
  endfunction

  function automatic logic [1:0] mode_f(input int a);
    logic [31:0] h;
    h = mix(a * 16 + 14);
    return h[1:0];
  endfunction

  function automatic logic [127:0] img_f(input int a);
    logic [127:0] v;
    case (a)
      0: for (int k = 0; k < 16; k++) v[8*k +: 8] = 8'(k);
      1, 2: v = {16{8'h10}};
      3: v = {16{8'hFF}};
      4: v = {16{8'h01}};
      default: begin
        for (int q = 0; q < 4; q++) v[32*q +: 32] = mix(a * 16 + q);
        if (mode_f(a) == 2'd1) v = v & {16{8'h1F}};
      end
    endcase
    return v;
  endfunction

  function automatic logic [71:0] kern_f(input int ch, input int a);
    logic [95:0] r;
    logic [71:0] k;
    case (a)
      0: case (ch)
           0: k = 72'h01 << 32;           // identity: w[1][1] = 1
           1: k = {9{8'h01}};
           default: k = {9{8'hFF}};
         endcase
      1, 2, 3: k = {9{8'h01}};
      4: k = {9{8'hFF}};
      default: begin
        r = {mix(a * 16 + 4 + 3 * ch), mix(a * 16 + 5 + 3 * ch), mix(a * 16 + 6 + 3 * ch)};
        k = r[71:0];
        for (int i = 0; i < 9; i++) begin
          if (mode_f(a) == 2'd1)      k[8*i +: 8] = {{4{k[8*i+3]}}, k[8*i +: 4]};
          else if (mode_f(a) == 2'd2) k[8*i +: 8] = {{6{k[8*i+1]}}, k[8*i +: 2]};
        end
      end
    endcase
    return k;
  endfunction

  function automatic logic [1:0] sh_f(input int a);
    logic [31:0] h;
    case (a)
      0, 1, 4: return 2'd0;
      2: return 2'd2;
      3: return 2'd3;
      default: begin
        h = mix(a * 16 + 15);
        return h[1:0];
      end
    endcase
  endfunction

  // Reference: integer arithmetic straight from the pixel/weight formulas.
  function automatic logic [7:0] model(input logic [127:0] img, input logic [71:0] k,
                                       input logic [1:0] sh);
    int s, m, px, wt;
    logic [7:0] b;
    m = -2147483647;
    for (int a = 0; a < 2; a++) begin
      for (int c = 0; c < 2; c++) begin
        s = 0;
        for (int i = 0; i < 3; i++) begin
          for (int j = 0; j < 3; j++) begin
            b  = img[8*(4*(a+i) + c + j) +: 8];
            px = int'(b);
            b  = k[8*(3*i + j) +: 8];
            wt = int'($signed(b));
            s  = s + px * wt;
          end
        end
        if (s > m) m = s;
      end
    end
    if (m < 0) m = 0;
    m = m >> sh;
    if (m > 255) m = 255;
    return 8'(m);
  endfunction

  // ---------------- synchronous input memory + scoreboard push ----------------
  initial begin
    logic        re_s;
    int          a_s;
    exp_t        e;
    image_4x4     = '0;
    conv_kernel_0 = '0;
    conv_kernel_1 = '0;
    conv_kernel_2 = '0;
    shift         = '0;
    forever begin
      @(negedge clk);
      re_s = input_re;
      a_s  = int'(input_addr);
      @(posedge clk);
      #1;
      if (re_s && rst_n === 1'b1) begin
        image_4x4     = img_f(a_s);
        conv_kernel_0 = kern_f(0, a_s);
        conv_kernel_1 = kern_f(1, a_s);
        conv_kernel_2 = kern_f(2, a_s);
        shift         = sh_f(a_s);
        e.addr = a_s;
        e.y0   = model(image_4x4, conv_kernel_0, shift);
        e.y1   = model(image_4x4, conv_kernel_1, shift);
        e.y2   = model(image_4x4, conv_kernel_2, shift);
        sb.push_back(e);
      end
    end
  end

  // ---------------- write monitor ----------------
  initial begin
    exp_t        e;
    logic [23:0] known;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && (output_we_0 || output_we_1 || output_we_2)) begin
        check("we_lockstep", {29'd0, output_we_0, output_we_1, output_we_2}, 32'd7);
        if (sb.size() == 0) begin
          check("unexpected_write", {16'd0, output_addr_0}, 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("waddr0", {16'd0, output_addr_0}, e.addr);
          check("waddr1", {16'd0, output_addr_1}, e.addr);
          check("waddr2", {16'd0, output_addr_2}, e.addr);
          check("wcycle", cyc, e.addr + 3);
          check("y_all", {8'd0, y_0, y_1, y_2}, {8'd0, e.y0, e.y1, e.y2});
          if (e.addr < 5) begin
            case (e.addr)
              0:       known = 24'h0A5A00;
              1:       known = 24'h909090;
              2:       known = 24'h242424;
              3:       known = 24'hFFFFFF;
              default: known = 24'h000000;
            endcase
            check("y_directed", {8'd0, y_0, y_1, y_2}, {8'd0, known});
          end
          last_y       = {e.y0, e.y1, e.y2};
          last_wr_addr = e.addr;
          last_wr_cyc  = cyc;
          n_wr++;
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;
    cyc   = -1;
    @(negedge clk);
    check("first_re",   {31'd0, input_re}, 1);
    check("first_addr", {16'd0, input_addr}, 0);

    while (cyc < 1000) @(negedge clk);
    check("run1_re",   {31'd0, input_re}, 1);
    check("run1_addr", {16'd0, input_addr}, 1000);

    // asynchronous reset in the middle of a cycle
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    n_wr = 0;
    #1;
    check_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    check_zero("reset_hold");
    rst_n = 1'b1;
    cyc   = -1;
    @(negedge clk);
    check("restart_re",   {31'd0, input_re}, 1);
    check("restart_addr", {16'd0, input_addr}, 0);

    while (cyc < NUM_BLKS - 1) @(negedge clk);
    check("last_fetch_re",   {31'd0, input_re}, 1);
    check("last_fetch_addr", {16'd0, input_addr}, NUM_BLKS - 1);
    @(negedge clk);
    check("done_re",   {31'd0, input_re}, 0);
    check("done_addr", {16'd0, input_addr}, NUM_BLKS - 1);

    while (cyc < NUM_BLKS + 9) @(negedge clk);
    check("done_re_late", {31'd0, input_re}, 0);
    check("write_count",  n_wr, NUM_BLKS);
    check("last_wr_addr", last_wr_addr, NUM_BLKS - 1);
    check("last_wr_cyc",  last_wr_cyc, NUM_BLKS + 2);
    check("sb_empty",     sb.size(), 0);
    check("y_hold",       {8'd0, y_0, y_1, y_2}, {8'd0, last_y});
    check("addr_hold",    {16'd0, output_addr_0}, NUM_BLKS - 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    n_bad++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/conv_pool.md
Name: conv_pool

Overview:
Streaming 3-channel convolution + 2x2 max-pool engine. Reads a 4x4 block of 8-bit pixels per cycle from an external synchronous memory. Convolves each block with three 3x3 kernels (valid mode, 2x2 result) and max-pools each 2x2 result to one 8-bit value per kernel. Each of the three values is written to its own output memory at the block's index.

Parameters:
ADDR_W, 16, width of input/output block addresses
NUM_BLKS, 65536, number of blocks processed per run (addresses 0..NUM_BLKS-1)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
image_4x4  in  128  pixel p[r][c] = bits [8*(4r+c)+:8], unsigned, r/c = 0..3, row 0 at LSB end
conv_kernel_0  in  72  weight w[i][j] = bits [8*(3i+j)+:8], signed two's complement, i/j = 0..2
conv_kernel_1  in  72  same format, channel 1
conv_kernel_2  in  72  same format, channel 2
shift  in  2  right-shift amount applied before saturation
input_re  out  1  input memory read enable
input_addr  out  ADDR_W  input block address
output_we_0/1/2  out  1  write enable, channel k
output_addr_0/1/2  out  ADDR_W  write address, channel k
y_0/y_1/y_2  out  8  result, channel k

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, pipeline valids cleared, block counter 0.
- Fetch: from the first rising edge after reset release, input_re=1 and input_addr=n in cycle n, for n=0..NUM_BLKS-1, one block per cycle with no bubbles.
- After address NUM_BLKS-1: input_re=0, input_addr holds NUM_BLKS-1, done flag set. The block stays idle until the next reset; there is no wrap-around.
- Memory latency: image_4x4 for address n is valid in cycle n+1. conv_kernel_*, and shift are sampled in the same cycle n+1 and carried along the pipeline with the data.
- Stage 1 (registered at end of n+1): for each channel and each window (a,b) in {0,1}^2, S[a][b] = sum over i,j of p[a+i][b+j]*w[i][j].
  - Products: 8u x 8s signed. Accumulator: 20-bit signed, no overflow possible.
- Stage 2 (registered at end of n+2):
  - M = signed max of the four S.
  - R = M<0 ? 0 : M (ReLU).
  - T = R >> shift (logical).
  - y = T>255 ? 255 : T[7:0].
- Output in cycle n+3: output_we_k=1, output_addr_k=n, y_k valid, all three channels in lockstep.
- Latency from input_addr to write: 3 cycles. Throughput: 1 block/cycle. The last write (addr NUM_BLKS-1) occurs in cycle NUM_BLKS+2.
- output_we_k=0 whenever no valid block is in the final stage. While output_we_k=0, y_k and output_addr_k hold their last value.
- Reset mid-run: outputs drop to 0 immediately and in-flight blocks are discarded. After release, fetching restarts at address 0.
- Kernel/shift change mid-run: takes effect for blocks whose data arrives in the cycle the new value is presented. No stall.

Decomposition:
- Package conv_pool_pkg: PIX_W=8, WGT_W=8, ACC_W=20, KSZ=3, BLK=4, typedefs pix_t (unsigned 8), wgt_t (signed 8), acc_t (signed 20), and a helper function for ReLU/shift/saturate.
- One sub-module conv_pool_lane: one channel's conv (4 windows) + max + ReLU/shift/saturate, 2 pipeline stages. Instantiated 3 times.
- The top holds the address counter, valid/address pipeline, and the fetch controller.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles -> all outputs 0. First cycle after release: input_re=1, input_addr=0. First write (addr 0) exactly 3 cycles later.
- Identity kernel (w[1][1]=0x01, others 0), shift=0, pixels p[r][c]=4r+c -> y=0x0A (max of 5,6,9,10) on all channels using that kernel.
- All-ones kernel, all pixels 0x10:
  - shift=0 -> y=0x90.
  - shift=2 -> y=0x24.
  - pixels 0xFF, shift=3 -> 2295>>3=286 -> y=0xFF (saturation).
- Kernel all 0xFF (-1), pixels all 0x01 -> sums -9 -> y=0x00 (ReLU). Mixed channels: k0 identity, k1 all-ones, k2 all -1 checked simultaneously.
- Full run of 65536 random blocks vs software model:
  - every address written exactly once per channel;
  - last write addr 0xFFFF in cycle 65538;
  - input_re low thereafter, no further writes.
- Assert rst_n=0 asynchronously mid-cycle at block 1000 -> outputs 0 immediately. After release, fetch restarts at 0 and results match the model.
